eye_tracker_host_cmd: RTL and testbench

- Byte-command sequencer between the UART byte receiver/transmitter and the EyeTracker register block.
- Parses host commands from the received byte stream: write 'W' (0x57) and read 'R' (0x52), each followed by an address byte.
- Drives one-hot write/read strobes and the write data into the register block.
- Returns the read data, or a write acknowledge, over the UART transmit handshake.
- Recovers from broken or partial frames with an inter-byte timeout.

---
 rtl/eye_tracker_pkg.sv | 29 ++
 rtl/eye_tracker_cmd_timeout.sv | 37 +++
 rtl/eye_tracker_host_cmd.sv | 182 ++++++++++++++++++
 tb/tb_eye_tracker_host_cmd.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/eye_tracker_pkg.sv
// Shared constants for the EyeTracker host command path: command bytes,
// response bytes, sequencer state encoding and the register address map.
package eye_tracker_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WSTB = 3'd3,
        ST_RSTB = 3'd4,
        ST_TX   = 3'd5
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

    localparam int REG_UART_SW      = 0;
    localparam int REG_VGA_OUT_MODE = 1;
    localparam int REG_THRESHOLD    = 2;
    localparam int REG_RESERVED     = 3;

endpackage

// File: rtl/eye_tracker_cmd_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT_CYC-1.
module eye_tracker_cmd_timeout #(
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/eye_tracker_host_cmd.sv
// Host byte-command sequencer: parses 'W'/'R' frames from the UART stream,
// strobes the register block and returns read data or a write acknowledge.
module eye_tracker_host_cmd
    import eye_tracker_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int TIMEOUT_CYC = 2500000,
    parameter bit ACK_EN      = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iRX_VALID,
    input  logic [DATA_WIDTH-1:0] iRX_DATA,
    output logic                  oTX_VALID,
    output logic [DATA_WIDTH-1:0] oTX_DATA,
    input  logic                  iTX_READY,
    output logic [NUM_REGS-1:0]   oWE_BIT,
    output logic [NUM_REGS-1:0]   oRE_BIT,
    output logic [DATA_WIDTH-1:0] oDATA,
    input  logic [DATA_WIDTH-1:0] iRD,
    output logic                  oBUSY,
    output logic                  oERR
);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [NUM_REGS-1:0]   we_q, we_d;
    logic [NUM_REGS-1:0]   re_q, re_d;
    logic                  err_q, err_d;

    logic                  byte_acc;
    logic                  tmo_en;
    logic                  tmo_expire;
    logic [NUM_REGS-1:0]   addr_hit;
    logic [NUM_REGS-1:0]   rx_hit;
    logic                  addr_ok;

    // Full-width address compare, so any byte at or above NUM_REGS decodes to no bit.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign addr_hit[gi] = (addr_q   == DATA_WIDTH'(gi));
        assign rx_hit[gi]   = (iRX_DATA == DATA_WIDTH'(gi));
    end
    assign addr_ok = |addr_hit;

    assign tmo_en = (state_q == ST_ADDR) || (state_q == ST_DATA);

    eye_tracker_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (byte_acc || !tmo_en),
        .en_i    (tmo_en),
        .expire_o(tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tx_data_d = tx_data_q;
        we_d      = '0;
        re_d      = '0;
        err_d     = err_q;
        byte_acc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iRX_VALID) begin
                    if (iRX_DATA == DATA_WIDTH'(CMD_WR)) begin
                        op_d     = OP_WR;
                        state_d  = ST_ADDR;
                        byte_acc = 1'b1;
                    end else if (iRX_DATA == DATA_WIDTH'(CMD_RD)) begin
                        op_d     = OP_RD;
                        state_d  = ST_ADDR;
                        byte_acc = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (iRX_VALID) begin
                    addr_d   = iRX_DATA;
                    byte_acc = 1'b1;
                    if (op_q == OP_WR) begin
                        state_d = ST_DATA;
                    end else begin
                        // Read select is registered so it lines up with the RSTB cycle.
                        re_d    = rx_hit;
                        state_d = ST_RSTB;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (iRX_VALID) begin
                    data_d   = iRX_DATA;
                    byte_acc = 1'b1;
                    we_d     = addr_hit;
                    state_d  = ST_WSTB;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WSTB: begin
                if (!addr_ok || iRX_VALID) begin
                    err_d = 1'b1;
                end
                if (ACK_EN) begin
                    tx_data_d = DATA_WIDTH'(ACK_BYTE);
                    state_d   = ST_TX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSTB: begin
                if (addr_ok) begin
                    tx_data_d = iRD;
                end else begin
                    tx_data_d = DATA_WIDTH'(NAK_BYTE);
                    err_d     = 1'b1;
                end
                if (iRX_VALID) begin
                    err_d = 1'b1;
                end
                state_d = ST_TX;
            end
            ST_TX: begin
                if (iRX_VALID) begin
                    err_d = 1'b1;
                end
                if (iTX_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_WR;
            addr_q    <= '0;
            data_q    <= '0;
            tx_data_q <= '0;
            we_q      <= '0;
            re_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tx_data_q <= tx_data_d;
            we_q      <= we_d;
            re_q      <= re_d;
            err_q     <= err_d;
        end
    end

    assign oTX_VALID = (state_q == ST_TX);
    assign oTX_DATA  = tx_data_q;
    assign oWE_BIT   = we_q;
    assign oRE_BIT   = re_q;
    assign oDATA     = data_q;
    assign oBUSY     = (state_q != ST_IDLE);
    assign oERR      = err_q;

endmodule

// File: tb/tb_eye_tracker_host_cmd.sv
// Directed bench for the host command sequencer with a small register read model.
module tb_eye_tracker_host_cmd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic [3:0] we_bit;
    logic [3:0] re_bit;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int we_pulses = 0;
    int re_pulses = 0;
    int base_we;
    int base_re;

    always #5 clk = ~clk;

    eye_tracker_host_cmd #(
        .DATA_WIDTH (8),
        .NUM_REGS   (4),
        .TIMEOUT_CYC(16),
        .ACK_EN     (1'b1)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .iRX_VALID(rx_valid),
        .iRX_DATA (rx_data),
        .oTX_VALID(tx_valid),
        .oTX_DATA (tx_data),
        .iTX_READY(tx_ready),
        .oWE_BIT  (we_bit),
        .oRE_BIT  (re_bit),
        .oDATA    (wdata),
        .iRD      (rd),
        .oBUSY    (busy),
        .oERR     (err)
    );

    always_comb begin
        rd = 8'h00;
        if (re_bit == 4'b0100) rd = 8'h80;
        else if (re_bit == 4'b0010) rd = 8'h5A;
    end

    always @(negedge clk) begin
        if (we_bit != 4'b0000) we_pulses++;
        if (re_bit != 4'b0000) re_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Accept the pending TX byte and confirm valid drops the next cycle.
    task automatic accept_tx(input string tag);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check({tag, "_txv_drop"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_txv",  {31'd0, tx_valid}, 32'd0);
        check("rst_txd",  {24'd0, tx_data}, 32'd0);
        check("rst_we",   {28'd0, we_bit}, 32'd0);
        check("rst_re",   {28'd0, re_bit}, 32'd0);
        check("rst_data", {24'd0, wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x80 to THRESHOLD
        base_we = we_pulses;
        send_byte(8'h57); send_byte(8'h02); send_byte(8'h80);
        check("wr_we",   {28'd0, we_bit}, 32'h4);
        check("wr_data", {24'd0, wdata}, 32'h80);
        @(negedge clk);
        check("wr_we_off", {28'd0, we_bit}, 32'h0);
        check("wr_txv",    {31'd0, tx_valid}, 32'd1);
        check("wr_ack",    {24'd0, tx_data}, 32'h4B);
        check("wr_pulses", we_pulses - base_we, 32'd1);
        accept_tx("wr");
        check("wr_err", {31'd0, err}, 32'd0);

        // Read THRESHOLD with backpressure
        base_re = re_pulses;
        send_byte(8'h52); send_byte(8'h02);
        check("rd_re", {28'd0, re_bit}, 32'h4);
        @(negedge clk);
        check("rd_re_off", {28'd0, re_bit}, 32'h0);
        check("rd_txv",    {31'd0, tx_valid}, 32'd1);
        check("rd_txd",    {24'd0, tx_data}, 32'h80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_hold_v", {31'd0, tx_valid}, 32'd1);
            check("rd_hold_d", {24'd0, tx_data}, 32'h80);
        end
        check("rd_pulses", re_pulses - base_re, 32'd1);
        accept_tx("rd");
        check("rd_err", {31'd0, err}, 32'd0);

        // Bad read address
        base_re = re_pulses;
        send_byte(8'h52); send_byte(8'h07);
        check("bad_rd_re", {28'd0, re_bit}, 32'h0);
        @(negedge clk);
        check("bad_rd_nak", {24'd0, tx_data}, 32'hEE);
        check("bad_rd_err", {31'd0, err}, 32'd1);
        check("bad_rd_pulses", re_pulses - base_re, 32'd0);
        accept_tx("bad_rd");

        // Bad write address
        do_reset();
        base_we = we_pulses;
        send_byte(8'h57); send_byte(8'h09); send_byte(8'h11);
        check("bad_wr_we", {28'd0, we_bit}, 32'h0);
        @(negedge clk);
        check("bad_wr_ack", {24'd0, tx_data}, 32'h4B);
        check("bad_wr_txv", {31'd0, tx_valid}, 32'd1);
        check("bad_wr_err", {31'd0, err}, 32'd1);
        check("bad_wr_pulses", we_pulses - base_we, 32'd0);
        accept_tx("bad_wr");

        // Timeout in DATA: expires on the 16th idle cycle
        do_reset();
        base_we = we_pulses;
        send_byte(8'h57); send_byte(8'h01);
        repeat (15) @(negedge clk);
        check("tmo_busy_15", {31'd0, busy}, 32'd1);
        check("tmo_err_15",  {31'd0, err}, 32'd0);
        @(negedge clk);
        check("tmo_busy_16", {31'd0, busy}, 32'd0);
        check("tmo_err_16",  {31'd0, err}, 32'd1);
        check("tmo_pulses", we_pulses - base_we, 32'd0);
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h01);
        check("tmo_rewr_we",   {28'd0, we_bit}, 32'h2);
        check("tmo_rewr_data", {24'd0, wdata}, 32'h01);
        @(negedge clk);
        check("tmo_rewr_ack", {24'd0, tx_data}, 32'h4B);
        accept_tx("tmo_rewr");

        // Garbage byte in IDLE
        do_reset();
        send_byte(8'h41);
        check("garb_busy", {31'd0, busy}, 32'd0);
        check("garb_err",  {31'd0, err}, 32'd1);

        // Overrun during TX wait
        do_reset();
        send_byte(8'h52); send_byte(8'h01);
        @(negedge clk);
        check("ovr_txd0", {24'd0, tx_data}, 32'h5A);
        check("ovr_err0", {31'd0, err}, 32'd0);
        send_byte(8'h33);
        check("ovr_txd", {24'd0, tx_data}, 32'h5A);
        check("ovr_txv", {31'd0, tx_valid}, 32'd1);
        check("ovr_err", {31'd0, err}, 32'd1);
        accept_tx("ovr");

        // Reset during TX: async clear
        do_reset();
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
        @(negedge clk);
        check("mtx_txv_pre", {31'd0, tx_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mtx_txv",  {31'd0, tx_valid}, 32'd0);
        check("mtx_txd",  {24'd0, tx_data}, 32'd0);
        check("mtx_data", {24'd0, wdata}, 32'd0);
        check("mtx_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-command; a lone address byte afterwards is garbage
        base_we = we_pulses;
        send_byte(8'h57); send_byte(8'h00);
        check("mcmd_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mcmd_busy", {31'd0, busy}, 32'd0);
        check("mcmd_err",  {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h01);
        @(negedge clk);
        check("mcmd_lone_err",  {31'd0, err}, 32'd1);
        check("mcmd_lone_busy", {31'd0, busy}, 32'd0);
        check("mcmd_pulses", we_pulses - base_we, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
